// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl
//   Multi-cycle multiply/divide controller that owns the HI/LO registers of
//   the 5-stage MIPS pipeline. It sits beside EX, takes the post-forwarding
//   operands, runs a 32-iteration shift-add multiplier or restoring divider,
//   applies sign fix-up, and writes HI/LO. MTHI/MTLO complete in one cycle.
//
//   Handshake: an instruction is offered by holding start high with op/src_*
//   valid. A MULT/DIV-class op is accepted in the cycle it is seen in IDLE
//   without flush; stall then stays high for exactly 34 cycles (accept,
//   32 CALC, FIX) and the DONE cycle lets the same instruction leave EX with
//   start ignored. MTHI/MTLO are accepted with zero stall. flush aborts the
//   offered or in-flight operation without touching HI/LO.
//
// Ports
//   clk    in   pipeline clock, rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   HI/LO instruction valid in EX
//   op     in   [2:0] 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   src_a  in   [31:0] rs: multiplicand / dividend / MTHI-MTLO data
//   src_b  in   [31:0] rt: multiplier / divisor
//   flush  in   kills the EX instruction (abort)
//   stall  out  combinational hold request for IF/ID/EX
//   busy   out  registered, high in CALC and FIX
//   hi     out  [31:0] HI register
//   lo     out  [31:0] LO register
module muldiv_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic        flush,
   output logic        stall,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state;
   logic [4:0]  cnt;
   logic        is_div;
   logic        is_signed;
   logic        sa;
   logic        sb;
   logic        div_zero;
   logic [31:0] mag_a;
   logic [31:0] mag_b;
   logic [31:0] orig_a;
   logic [63:0] acc;

   logic        accept_md;
   logic        op_signed;
   logic [31:0] abs_a;
   logic [31:0] abs_b;
   logic [32:0] mul_sum;
   logic [32:0] div_shift;
   logic [32:0] div_trial;
   logic        q_bit;
   logic [31:0] div_rem_next;
   logic [63:0] acc_next;
   logic [63:0] fix_prod;
   logic [31:0] fix_quo;
   logic [31:0] fix_rem;
   logic [31:0] fix_hi;
   logic [31:0] fix_lo;

   assign accept_md = start & ~flush & (op <= 3'd3);
   // MULT and DIV are the even codes among 0-3.
   assign op_signed = ~op[0];

   assign stall = rst_n & ~flush &
                  (((state == S_IDLE) & start & (op <= 3'd3)) |
                   (state == S_CALC) | (state == S_FIX));

   always_comb begin
      abs_a = src_a;
      abs_b = src_b;
      if (op_signed && src_a[31]) abs_a = 32'd0 - src_a;
      if (op_signed && src_b[31]) abs_b = 32'd0 - src_b;
   end

   // One iteration of either datapath. acc layout:
   //   multiply: {partial product high, shifted-out product low}
   //   divide:   {partial remainder, quotient bits shifted in from the right}
   always_comb begin
      mul_sum      = {1'b0, acc[63:32]} + (mag_b[cnt] ? {1'b0, mag_a} : 33'd0);
      div_shift    = {acc[63:32], mag_a[5'd31 - cnt]};
      div_trial    = div_shift - {1'b0, mag_b};
      // Non-negative trial difference means the divisor fits: keep it.
      q_bit        = ~div_trial[32];
      div_rem_next = q_bit ? div_trial[31:0] : div_shift[31:0];
      if (is_div) acc_next = {div_rem_next, acc[30:0], q_bit};
      else        acc_next = {mul_sum, acc[31:1]};
   end

   // Sign fix-up and HI/LO selection applied in FIX.
   always_comb begin
      fix_prod = acc;
      fix_quo  = acc[31:0];
      fix_rem  = acc[63:32];
      if (is_signed && (sa ^ sb)) begin
         fix_prod = 64'd0 - acc;
         fix_quo  = 32'd0 - acc[31:0];
      end
      if (is_signed && sa) fix_rem = 32'd0 - acc[63:32];
      if (!is_div) begin
         fix_hi = fix_prod[63:32];
         fix_lo = fix_prod[31:0];
      end else if (div_zero) begin
         // Divide by zero: all-ones quotient, untouched original dividend.
         fix_hi = orig_a;
         fix_lo = 32'hFFFF_FFFF;
      end else begin
         fix_hi = fix_rem;
         fix_lo = fix_quo;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         cnt       <= 5'd0;
         busy      <= 1'b0;
         hi        <= 32'd0;
         lo        <= 32'd0;
         is_div    <= 1'b0;
         is_signed <= 1'b0;
         sa        <= 1'b0;
         sb        <= 1'b0;
         div_zero  <= 1'b0;
         mag_a     <= 32'd0;
         mag_b     <= 32'd0;
         orig_a    <= 32'd0;
         acc       <= 64'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept_md) begin
                  state     <= S_CALC;
                  busy      <= 1'b1;
                  cnt       <= 5'd0;
                  acc       <= 64'd0;
                  is_div    <= op[1];
                  is_signed <= op_signed;
                  sa        <= op_signed & src_a[31];
                  sb        <= op_signed & src_b[31];
                  div_zero  <= op[1] & (src_b == 32'd0);
                  mag_a     <= abs_a;
                  mag_b     <= abs_b;
                  orig_a    <= src_a;
               end else if (start && !flush && op == 3'd4) begin
                  hi <= src_a;
               end else if (start && !flush && op == 3'd5) begin
                  lo <= src_a;
               end
            end
            S_CALC: begin
               if (flush) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
                  cnt   <= 5'd0;
               end else begin
                  acc <= acc_next;
                  cnt <= cnt + 5'd1;
                  if (cnt == 5'd31) state <= S_FIX;
               end
            end
            S_FIX: begin
               state <= flush ? S_IDLE : S_DONE;
               busy  <= 1'b0;
               cnt   <= 5'd0;
               if (!flush) begin
                  hi <= fix_hi;
                  lo <= fix_lo;
               end
            end
            S_DONE: begin
               // The finished instruction is still presented; start is ignored.
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl. Inputs change on the falling edge and
// outputs are sampled 1 ns later, away from the rising (active) edge.
module tb_muldiv_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic        flush;
   logic        stall;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   int vectors;
   int miscompares;

   muldiv_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .flush (flush),
      .stall (stall),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   // Offer a MULT/DIV-class op, hold it (as EX would) through DONE, count
   // stall cycles, then check HI/LO in the DONE cycle and idle afterwards.
   task automatic do_op(input string tag, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      next_cycle();
      start = 1'b1; op = o; src_a = a; src_b = b;
      #1;
      n = 0;
      while (stall && n < 100) begin
         n++;
         next_cycle();
         src_a = $urandom;
         src_b = $urandom;
         #1;
         if (n == 1) chk({tag, "_busy_c1"}, {31'd0, busy}, 32'd1);
      end
      chk({tag, "_stall_cycles"}, n, 32'd34);
      chk({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
      chk({tag, "_hi"}, hi, exp_hi);
      chk({tag, "_lo"}, lo, exp_lo);
      next_cycle();
      start = 1'b0;
      #1;
      chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
      chk({tag, "_stall_after"}, {31'd0, stall}, 32'd0);
   endtask

   initial begin
      logic [31:0] lo_before;
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0; start = 1'b1; op = 3'd0; src_a = 32'd5; src_b = 32'd5; flush = 1'b0;

      // Reset overrides start.
      next_cycle();
      #1 chk("stall_in_reset", {31'd0, stall}, 32'd0);
      next_cycle();
      rst_n = 1'b1; start = 1'b0;
      #1;
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_stall", {31'd0, stall}, 32'd0);

      // Multiply
      do_op("mult_neg1x7",   3'd0, 32'hFFFF_FFFF, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFF9);
      do_op("multu_max",     3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      do_op("mult_m3xm5",    3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'h0000_000F);

      // Divide
      do_op("div_m7_2",      3'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
      do_op("div_7_m2",      3'd2, 32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
      do_op("divu_100_7",    3'd3, 32'd100,      32'd7,        32'd2,         32'd14);
      do_op("div_min_m1",    3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
      do_op("divu_by_zero",  3'd3, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF);
      do_op("div_by_zero",   3'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);

      // No-op codes do nothing.
      next_cycle();
      start = 1'b1; op = 3'd6; src_a = 32'h1111_1111;
      #1 chk("noop_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      start = 1'b0;
      #1;
      chk("noop_busy", {31'd0, busy}, 32'd0);
      chk("noop_hi", hi, 32'hFFFF_FFF9);
      chk("noop_lo", lo, 32'hFFFF_FFFF);

      // MTHI preload, then MULT flushed in cycle 10, then MTLO in cycle 11.
      lo_before = lo;
      next_cycle();
      start = 1'b1; op = 3'd4; src_a = 32'h0000_ABCD;
      #1 chk("mthi_stall", {31'd0, stall}, 32'd0);
      next_cycle();
      start = 1'b1; op = 3'd0; src_a = 32'd3; src_b = 32'd5;
      #1;
      chk("mthi_hi", hi, 32'h0000_ABCD);
      chk("flush_c0_stall", {31'd0, stall}, 32'd1);
      repeat (10) next_cycle();
      flush = 1'b1;
      #1;
      chk("flush_c10_stall", {31'd0, stall}, 32'd0);
      chk("flush_c10_busy", {31'd0, busy}, 32'd1);
      next_cycle();
      flush = 1'b0; start = 1'b1; op = 3'd5; src_a = 32'h0000_0055;
      #1;
      chk("flush_c11_stall", {31'd0, stall}, 32'd0);
      chk("flush_c11_busy", {31'd0, busy}, 32'd0);
      chk("flush_c11_hi", hi, 32'h0000_ABCD);
      chk("flush_c11_lo", lo, lo_before);
      next_cycle();
      start = 1'b0;
      #1;
      chk("mtlo_lo", lo, 32'h0000_0055);
      chk("mtlo_hi", hi, 32'h0000_ABCD);
      chk("mtlo_busy", {31'd0, busy}, 32'd0);

      // Reset in cycle 20 of a DIVU.
      next_cycle();
      start = 1'b1; op = 3'd3; src_a = 32'd1000; src_b = 32'd3;
      repeat (19) next_cycle();
      #1 chk("rst_mid_busy_c19", {31'd0, busy}, 32'd1);
      next_cycle();
      rst_n = 1'b0;
      #1 chk("rst_mid_stall_c20", {31'd0, stall}, 32'd0);
      next_cycle();
      rst_n = 1'b1; start = 1'b0;
      #1;
      chk("rst_mid_hi", hi, 32'd0);
      chk("rst_mid_lo", lo, 32'd0);
      chk("rst_mid_busy", {31'd0, busy}, 32'd0);
      chk("rst_mid_stall", {31'd0, stall}, 32'd0);

      // Block is usable again after the abort.
      do_op("divu_after_rst", 3'd3, 32'd1000, 32'd3, 32'd1, 32'd333);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
